// File: rtl/dac_sample_sched.sv
// Sample-rate tick generator and round-robin two-requester arbiter feeding a serial DAC.
// Loads are spaced by at least MIN_GAP cycles; ticks that land inside a load sequence are counted as overruns.
module dac_sample_sched #(
  parameter int unsigned CLK_DIV = 5000,
  parameter int unsigned MIN_GAP = 1000,
  parameter int unsigned DW      = 10
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [DW-1:0] data_b,
  output logic          ack_b,
  output logic [DW-1:0] dac_data,
  output logic          dac_load,
  output logic          sample_tick,
  output logic          busy,
  output logic [7:0]    overrun_cnt
);

  localparam logic [15:0] TIMER_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_RELOAD   = 16'(MIN_GAP - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [15:0]   timer_q, timer_d;
  logic [15:0]   gap_q, gap_d;
  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    ovr_q, ovr_d;

  logic tick;
  logic any_req;
  logic winner;
  logic load_active;

  // Timer is parked at its reload value while disabled so the first tick
  // after enabling always lands a full period later.
  always_comb begin
    timer_d = TIMER_RELOAD;
    if (enable && (timer_q != 16'd0)) begin
      timer_d = timer_q - 16'd1;
    end
  end

  assign tick    = enable && (timer_q == 16'd0);
  assign any_req = req_a || req_b;

  always_comb begin
    winner = GRANT_A;
    if (req_a && req_b) begin
      winner = ~last_grant_q;
    end else if (req_b) begin
      winner = GRANT_B;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && any_req) begin
          state_d      = ST_LOAD;
          last_grant_d = winner;
          data_d       = (winner == GRANT_B) ? data_b : data_a;
        end
      end
      ST_LOAD: begin
        gap_d   = GAP_RELOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_GAP;
        gap_d   = GAP_RELOAD;
      end
    endcase
  end

  // A tick during a load sequence is dropped, not queued.
  always_comb begin
    ovr_d = ovr_q;
    if (tick && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      timer_q      <= TIMER_RELOAD;
      gap_q        <= GAP_RELOAD;
      state_q      <= ST_GAP;
      last_grant_q <= GRANT_B;
      data_q       <= '0;
      ovr_q        <= 8'd0;
    end else begin
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      ovr_q        <= ovr_d;
    end
  end

  // Gated by rst_n so a reset landing on the LOAD cycle never leaks a strobe.
  assign load_active = rst_n && (state_q == ST_LOAD);

  assign dac_load    = load_active;
  assign ack_a       = load_active && (last_grant_q == GRANT_A);
  assign ack_b       = load_active && (last_grant_q == GRANT_B);
  assign dac_data    = data_q;
  assign sample_tick = tick;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Bench for dac_sample_sched: two instances (100/40 and 20/40) share stimulus and are
// checked every cycle against a timestamp-based model, plus hand-computed spot values.
module tb_dac_sample_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic       req_a  = 1'b0;
  logic       req_b  = 1'b0;
  logic [9:0] data_a = '0;
  logic [9:0] data_b = '0;

  logic [1:0]       tick_w, busy_w, load_w, acka_w, ackb_w;
  logic [1:0][9:0]  data_w;
  logic [1:0][7:0]  ovr_w;

  dac_sample_sched #(.CLK_DIV(100), .MIN_GAP(40), .DW(10)) dut0 (
    .sysclk(clk), .rst_n(rst_n), .enable(enable),
    .req_a(req_a), .data_a(data_a), .ack_a(acka_w[0]),
    .req_b(req_b), .data_b(data_b), .ack_b(ackb_w[0]),
    .dac_data(data_w[0]), .dac_load(load_w[0]), .sample_tick(tick_w[0]),
    .busy(busy_w[0]), .overrun_cnt(ovr_w[0])
  );

  dac_sample_sched #(.CLK_DIV(20), .MIN_GAP(40), .DW(10)) dut1 (
    .sysclk(clk), .rst_n(rst_n), .enable(enable),
    .req_a(req_a), .data_a(data_a), .ack_a(acka_w[1]),
    .req_b(req_b), .data_b(data_b), .ack_b(ackb_w[1]),
    .dac_data(data_w[1]), .dac_load(load_w[1]), .sample_tick(tick_w[1]),
    .busy(busy_w[1]), .overrun_cnt(ovr_w[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel0  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: ticks come from the count of consecutive enabled cycles, busy is a
  // "free again at cycle N" timestamp, a load is a scheduled cycle number.
  int      run_m   [2];
  longint  free_m  [2];
  longint  load_m  [2];
  bit      whob_m  [2];
  bit      lastb_m [2];
  bit      valid_m [2];
  int      ovr_m   [2];
  int      data_m  [2];

  function automatic int cdiv(input int k);
    return (k == 0) ? 100 : 20;
  endfunction

  localparam int MG = 40;

  task automatic model_cycle(input int k);
    bit tk, bz, ld, wb;
    if (!rst_n) begin
      if (valid_m[k]) begin
        chk($sformatf("rst_load%0d", k), int'(load_w[k]), 0);
        chk($sformatf("rst_ack_a%0d", k), int'(acka_w[k]), 0);
        chk($sformatf("rst_ack_b%0d", k), int'(ackb_w[k]), 0);
      end
      run_m[k]   = 0;
      free_m[k]  = longint'(cyc) + 1 + MG;
      load_m[k]  = -1;
      lastb_m[k] = 1'b1;
      whob_m[k]  = 1'b0;
      ovr_m[k]   = 0;
      data_m[k]  = 0;
      valid_m[k] = 1'b1;
    end else if (valid_m[k]) begin
      tk = enable && ((run_m[k] % cdiv(k)) == cdiv(k) - 1);
      bz = longint'(cyc) < free_m[k];
      ld = longint'(cyc) == load_m[k];
      chk($sformatf("tick%0d", k), int'(tick_w[k]), int'(tk));
      chk($sformatf("busy%0d", k), int'(busy_w[k]), int'(bz));
      chk($sformatf("load%0d", k), int'(load_w[k]), int'(ld));
      chk($sformatf("ack_a%0d", k), int'(acka_w[k]), int'(ld && !whob_m[k]));
      chk($sformatf("ack_b%0d", k), int'(ackb_w[k]), int'(ld && whob_m[k]));
      chk($sformatf("data%0d", k), int'(data_w[k]), data_m[k]);
      chk($sformatf("ovr%0d", k), int'(ovr_w[k]), ovr_m[k]);
      if (tk) begin
        if (bz) begin
          if (ovr_m[k] < 255) ovr_m[k] = ovr_m[k] + 1;
        end else if (req_a || req_b) begin
          wb = (req_a && req_b) ? !lastb_m[k] : req_b;
          whob_m[k]  = wb;
          lastb_m[k] = wb;
          data_m[k]  = wb ? int'(data_b) : int'(data_a);
          load_m[k]  = longint'(cyc) + 1;
          free_m[k]  = longint'(cyc) + MG + 2;
        end
      end
      run_m[k] = enable ? run_m[k] + 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_cycle(k);
  end

  // Advance to #1 after the edge that starts relative cycle n.
  task automatic goto(input int n);
    while (cyc < rel0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spot(input int n);
    goto(n);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rel0   = cyc;
    rst_n  = 1'b1;
    enable = 1'b1;

    spot(39);  chk("pin_busy_39", int'(busy_w[0]), 1);
    spot(40);  chk("pin_busy_40", int'(busy_w[0]), 0);
    spot(98);  chk("pin_tick_98", int'(tick_w[0]), 0);
    spot(99);  chk("pin_tick_99", int'(tick_w[0]), 1);
               chk("pin_data_99", int'(data_w[0]), 0);

    goto(100); req_a = 1'b1; data_a = 10'h2AA;
    spot(200); chk("pin_load_200", int'(load_w[0]), 1);
               chk("pin_acka_200", int'(acka_w[0]), 1);
               chk("pin_ackb_200", int'(ackb_w[0]), 0);
               chk("pin_data_200", int'(data_w[0]), 'h2AA);
    spot(201); chk("pin_load_201", int'(load_w[0]), 0);
    spot(300); chk("pin_load_300", int'(load_w[0]), 1);

    goto(301); req_b = 1'b1; data_a = 10'h155; data_b = 10'h3FF;
    spot(400); chk("pin_ackb_400", int'(ackb_w[0]), 1);
               chk("pin_acka_400", int'(acka_w[0]), 0);
               chk("pin_data_400", int'(data_w[0]), 'h3FF);
    spot(500); chk("pin_acka_500", int'(acka_w[0]), 1);
               chk("pin_data_500", int'(data_w[0]), 'h155);
    spot(600); chk("pin_ackb_600", int'(ackb_w[0]), 1);
               chk("pin_data_600", int'(data_w[0]), 'h3FF);

    goto(601); req_b = 1'b0; data_a = 10'h123;
    goto(701); req_a = 1'b0;
    spot(799); chk("pin_tick_799", int'(tick_w[0]), 1);
    spot(800); chk("pin_load_800", int'(load_w[0]), 0);
               chk("pin_data_800", int'(data_w[0]), 'h123);
               chk("pin_ovr_800", int'(ovr_w[0]), 0);

    goto(801); req_a = 1'b1; data_a = 10'h0F0;
    goto(906); enable = 1'b0;
    spot(940); chk("pin_busy_940", int'(busy_w[0]), 1);
    spot(941); chk("pin_busy_941", int'(busy_w[0]), 0);
    spot(999); chk("pin_tick_999", int'(tick_w[0]), 0);
    goto(1000); enable = 1'b1;
    spot(1100); chk("pin_load_1100", int'(load_w[0]), 1);
                chk("pin_data_1100", int'(data_w[0]), 'h0F0);
    goto(1111); rst_n = 1'b0;
    goto(1112); rst_n = 1'b1;
    @(negedge clk);
    chk("pin_data_1112", int'(data_w[0]), 0);
    chk("pin_ovr0_1112", int'(ovr_w[0]), 0);
    chk("pin_ovr1_1112", int'(ovr_w[1]), 0);
    chk("pin_data1_1112", int'(data_w[1]), 0);
    chk("pin_busy_1112", int'(busy_w[0]), 1);
    spot(1151); chk("pin_busy_1151", int'(busy_w[0]), 1);
    spot(1152); chk("pin_busy_1152", int'(busy_w[0]), 0);
    spot(1172); chk("pin_load1_1172", int'(load_w[1]), 1);
    spot(1232); chk("pin_load1_1232", int'(load_w[1]), 1);
                chk("pin_ovr1_1232", int'(ovr_w[1]), 4);

    spot(10152); chk("pin_ovr1_sat", int'(ovr_w[1]), 255);
                 chk("pin_ovr0_none", int'(ovr_w[0]), 0);

    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 2) != 0);
      data_a = 10'($urandom_range(0, 1023));
      data_b = 10'($urandom_range(0, 1023));
      enable = ($urandom_range(0, 49) != 0);
      rst_n  = ($urandom_range(0, 2999) != 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
